uart_tx_arbiter: RTL and testbench

Shares the single transmit path of the board's uart block (wr_uart / w_data / tx_full) between N_REQ byte-stream requesters, e.g. channel-voltage reporter, command echo and debug dump. It grants one requester at a time, in round-robin order, and locks the grant for a whole packet (up to req_last) or for at most MAX_BURST bytes.
- Sits between the requesters and the uart instance, in the clk_50MHz domain.
- Guarantees no write is issued while the TX FIFO reports full.

---
 rtl/uart_arb_pkg.sv | 26 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart transmit arbiter: FSM encoding,
// a constant-foldable ceil(log2) helper and the default burst limit.
package uart_arb_pkg;

    // Arbiter FSM: IDLE searches for a requester, XFER owns the uart path.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Bytes accepted per grant before the grant is forcibly rotated.
    localparam int DEFAULT_MAX_BURST = 16;

    // Smallest r with 2**r >= value; bounded loop so it folds at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found when searching ptr, ptr+1, ... wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    int cand;

    // Walk offsets from the farthest to the nearest so the nearest match wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[cand]) begin
                found_o     = 1'b1;
                idx_o       = PW'(cand);
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart transmit path between N_REQ byte
// streams. A grant is held for one packet (through req_last) or at most
// MAX_BURST bytes, and no byte is accepted while the TX FIFO is full.
//
// Handshake: a requester presents req_valid with req_data/req_last and
// holds them stable until the cycle where req_valid && req_ready are both
// high at the rising edge; that is the only cycle data is sampled.
// req_ready is only ever raised for the current owner, never while
// tx_full is high and never in the cycle a write strobe is on wr_uart.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*DATA_W-1:0]            req_data,
    input  logic [N_REQ-1:0]                   req_last,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic                               tx_full,
    output logic                               wr_uart,
    output logic [DATA_W-1:0]                  w_data,
    output logic [N_REQ-1:0]                   grant,
    output logic                               busy,
    output arb_state_e                         dbg_state_o,
    output logic [clog2(N_REQ)-1:0]            dbg_ptr_o,
    output logic [clog2(MAX_BURST+1)-1:0]      dbg_burst_cnt_o
);

    localparam int PTR_W = clog2(N_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               wr_uart_q, wr_uart_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;

    logic               owner_valid;
    logic               owner_last;
    logic [DATA_W-1:0]  owner_data;
    logic               can_accept;
    logic               accept;
    logic [CNT_W-1:0]   burst_inc;
    logic               burst_done;

    rr_pick #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Mux the owner's valid/last/data out of the request vectors using the one-hot grant.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_valid = owner_valid | req_valid[i];
                owner_last  = owner_last  | req_last[i];
                owner_data  = owner_data  | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The !wr_uart_q term leaves a gap after every write so a full flag raised by it is seen.
    always_comb begin
        can_accept = (state_q == ST_XFER) && !tx_full && !wr_uart_q;
        accept     = can_accept && owner_valid;
        req_ready  = can_accept ? grant_q : '0;
        burst_inc  = burst_cnt_q + 1'b1;
        burst_done = (burst_inc == CNT_W'(MAX_BURST));
    end

    // Next-state logic: pick an owner in IDLE, move bytes and decide release in XFER.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        wr_uart_d   = 1'b0;
        w_data_d    = w_data_q;
        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    state_d     = ST_XFER;
                    grant_d     = pick_gnt;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    wr_uart_d   = 1'b1;
                    w_data_d    = owner_data;
                    burst_cnt_d = burst_inc;
                    if (owner_last || burst_done) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset abandons any packet in flight and any pending strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
            wr_uart_q   <= 1'b0;
            w_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            wr_uart_q   <= wr_uart_d;
            w_data_q    <= w_data_d;
        end
    end

    assign wr_uart         = wr_uart_q;
    assign w_data          = w_data_q;
    assign grant           = grant_q;
    assign busy            = (state_q == ST_XFER);
    assign dbg_state_o     = state_q;
    assign dbg_ptr_o       = ptr_q;
    assign dbg_burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester source queues drive the
// valid/ready streams, every byte's expected uart order is queued when it
// is posted, and the monitor pops and compares on each wr_uart strobe.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic                     clk;
  logic                     reset;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]         req_last;
  logic [N_REQ-1:0]         req_ready;
  logic                     tx_full;
  logic                     wr_uart;
  logic [DATA_W-1:0]        w_data;
  logic [N_REQ-1:0]         grant;
  logic                     busy;
  arb_state_e               dbg_state;
  logic [1:0]               dbg_ptr;
  logic [2:0]               dbg_burst_cnt;

  uart_tx_arbiter #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .tx_full         (tx_full),
    .wr_uart         (wr_uart),
    .w_data          (w_data),
    .grant           (grant),
    .busy            (busy),
    .dbg_state_o     (dbg_state),
    .dbg_ptr_o       (dbg_ptr),
    .dbg_burst_cnt_o (dbg_burst_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]        src_q [N_REQ][$];  // {last, byte} per requester
  logic [DATA_W-1:0] exp_q[$];          // expected uart byte order
  logic [N_REQ-1:0]  stall;
  logic [N_REQ-1:0]  hs_q;
  logic              prev_wr;
  int                strobe_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic post(input int r, input logic [7:0] b, input logic last);
    src_q[r].push_back({last, b});
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tx_full = 1'b0;
    stall = '0;
    for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic bit all_done();
    bit d;
    d = (exp_q.size() == 0);
    for (int i = 0; i < N_REQ; i++) if (src_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!all_done() && n < 400) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, 32'(all_done()), 32'd1);
  endtask

  // Requester models plus scoreboard monitor, all on the falling edge.
  always @(negedge clk) begin
    if (!reset) hs_q = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (hs_q[i] && src_q[i].size() != 0) src_q[i].delete(0);
    end
    hs_q = '0;
    if (wr_uart) begin
      strobe_cnt++;
      check("strobe_gap", 32'(prev_wr), 32'd0);
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("w_data", 32'(w_data), 32'(exp_q.pop_front()));
    end
    prev_wr = wr_uart;
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() != 0 && !stall[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = src_q[i][0][7:0];
        req_last[i] = src_q[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
        req_last[i] = 1'($urandom_range(0, 1));
      end
    end
    #4;
    if (reset) hs_q = req_valid & req_ready;
    if (req_ready != '0) check("ready_legal", 32'(((req_ready & ~grant) == '0) && !tx_full), 32'd1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset = 1'b0;
    tx_full = 1'b0;
    stall = '0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    hs_q = '0;
    prev_wr = 1'b0;
    strobe_cnt = 0;

    // Reset values while reset is held low.
    repeat (3) @(negedge clk);
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_wr_uart", 32'(wr_uart), 32'd0);
    check("rst_w_data", 32'(w_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    check("rst_burst", 32'(dbg_burst_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: single requester, 3-byte packet.
    @(posedge clk); #1;
    post(1, 8'h41, 1'b0);
    post(1, 8'h42, 1'b0);
    post(1, 8'h43, 1'b1);
    @(negedge clk); #2;
    check("t1_grant_pre", 32'(grant), 32'd0);
    @(negedge clk); #2;
    check("t1_grant", 32'(grant), 32'b0010);
    check("t1_busy", 32'(busy), 32'd1);
    wait_drain("t1_drain");
    check("t1_grant_after", 32'(grant), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_ptr_after", 32'(dbg_ptr), 32'd2);

    // 2: round robin, everyone posts 1-byte packets from reset.
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N_REQ; i++) post(i, 8'hA0 + 8'(i), 1'b1);
    @(negedge clk); #2;
    @(negedge clk); #2;
    check("t2_first_grant", 32'(grant), 32'b0001);
    wait_drain("t2_drain");

    // 3: backpressure mid-packet.
    do_reset();
    @(posedge clk); #1;
    for (int b = 0; b < 6; b++) post(3, 8'h30 + 8'(b), b == 5);
    while (exp_q.size() > 4) begin
      @(negedge clk); #2;
    end
    tx_full = 1'b1;
    s0 = strobe_cnt;
    repeat (10) begin
      @(negedge clk); #2;
      check("t3_ready_low", 32'(req_ready), 32'd0);
    end
    check("t3_no_strobe", 32'(strobe_cnt), 32'(s0));
    tx_full = 1'b0;
    wait_drain("t3_drain");

    // 4: forced rotation after MAX_BURST bytes.
    do_reset();
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) post(0, 8'h10 + 8'(b), 1'b0);
    post(2, 8'h20, 1'b0);
    post(2, 8'h21, 1'b0);
    post(2, 8'h22, 1'b1);
    for (int b = 4; b < 10; b++) begin
      src_q[0].push_back({1'b0, 8'h10 + 8'(b)});
      exp_q.push_back(8'h10 + 8'(b));
    end
    wait_drain("t4_drain");

    // 5: owner stalls mid-packet while others wait.
    do_reset();
    @(posedge clk); #1;
    post(0, 8'h60, 1'b1);
    for (int b = 0; b < 4; b++) post(1, 8'h50 + 8'(b), b == 3);
    post(2, 8'h62, 1'b1);
    while (exp_q.size() > 4) begin
      @(negedge clk); #2;
    end
    stall[1] = 1'b1;
    s0 = strobe_cnt;
    repeat (20) begin
      @(negedge clk); #2;
      check("t5_grant_held", 32'(grant), 32'b0010);
    end
    check("t5_no_strobe", 32'(strobe_cnt), 32'(s0));
    stall[1] = 1'b0;
    wait_drain("t5_drain");

    // 6: asynchronous reset between two accepts.
    do_reset();
    @(posedge clk); #1;
    post(1, 8'h71, 1'b0);
    post(1, 8'h72, 1'b0);
    post(1, 8'h73, 1'b1);
    while (exp_q.size() > 2) begin
      @(negedge clk); #2;
    end
    check("t6_strobe_seen", 32'(wr_uart), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_wr_uart", 32'(wr_uart), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_ptr", 32'(dbg_ptr), 32'd0);
    for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    post(1, 8'h81, 1'b1);
    post(3, 8'h83, 1'b1);
    src_q[3].push_back({1'b1, 8'h93});
    exp_q.push_back(8'h93);
    wait_drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
